// File: rtl/task_8_timer_ctrl_pkg.sv
// Shared encodings and sizing for the lap-timer controller.
// Build switch: TASK_8_TIMER_CTRL_DEBOUNCE_EN enables key debouncing.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int DEPTH_DEF = 10;
    localparam int ADDR_W    = 4;

endpackage

// File: rtl/task_8_timer_ctrl_if.sv
// Status/control bundle driven by the lap-timer controller.
// Build switch: TASK_8_TIMER_CTRL_DEBOUNCE_EN (no effect on this bundle).
interface task_8_timer_ctrl_if;
    import timer_pkg::*;

    logic              cnt_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              full;
    logic [1:0]        state;

    modport master (
        output cnt_en, wr_en, wr_addr, rd_addr, rd_valid, full, state
    );

    modport slave (
        input cnt_en, wr_en, wr_addr, rd_addr, rd_valid, full, state
    );

endinterface

// File: rtl/task_8_timer_ctrl_key_cond.sv
// Key conditioning: 2-flop sync, optional debounce, one-cycle press pulse.
// Build switch: TASK_8_TIMER_CTRL_DEBOUNCE_EN selects the debounce filter.
module timer_key_cond #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    if (DEBOUNCE_CYC < 1) begin : g_bad_deb
        $error("DEBOUNCE_CYC must be at least 1");
    end

    logic s1, s2;
    logic lvl, lvl_d;
    logic seen, armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

`ifdef TASK_8_TIMER_CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    logic [CW-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl    <= 1'b1;
            db_cnt <= '0;
        end else if (s2 == lvl) begin
            db_cnt <= '0;
        end else if (db_cnt == CW'(DEBOUNCE_CYC - 1)) begin
            lvl    <= s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CW'(1);
        end
    end
`else
    assign lvl = s2;
`endif

    // Arm only after a genuinely released key has been sampled, so a
    // key held across reset never produces a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d <= 1'b1;
            seen  <= 1'b0;
            armed <= 1'b0;
        end else begin
            lvl_d <= lvl;
            seen  <= 1'b1;
            if (seen && s1) armed <= 1'b1;
        end
    end

    assign press = armed & lvl_d & ~lvl;

endmodule

// File: rtl/task_8_timer_ctrl.sv
// Stopwatch lap controller: run/stop FSM, lap write and result browsing.
// Build switch: TASK_8_TIMER_CTRL_DEBOUNCE_EN enables key debouncing.
module task_8_timer_ctrl
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int DEPTH        = DEPTH_DEF
) (
    input  logic clk,
    input  logic key0_rst,
    input  logic key1_start_stop,
    input  logic key2_write,
    input  logic key3_show,
    task_8_timer_ctrl_if.master bus
);

    if (DEPTH < 1 || DEPTH > 15) begin : g_bad_depth
        $error("DEPTH must be in 1..15");
    end

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

    logic ss_p, wr_p, sh_p;
    logic ss, wr, sh;
    logic do_wr, do_sh;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] count_q, wr_addr_q, rd_addr_q;
    logic              cnt_en_q, wr_en_q, rd_valid_q, full_q;
    logic [ADDR_W-1:0] rd_inc;

    timer_key_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key1 (
        .clk(clk), .rst_n(key0_rst), .key_n(key1_start_stop), .press(ss_p)
    );
    timer_key_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key2 (
        .clk(clk), .rst_n(key0_rst), .key_n(key2_write), .press(wr_p)
    );
    timer_key_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key3 (
        .clk(clk), .rst_n(key0_rst), .key_n(key3_show), .press(sh_p)
    );

    always_ff @(posedge clk or negedge key0_rst) begin
        if (!key0_rst) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Pulses are masked by priority first so the decoder sees one-hot.
    always_comb begin
        ss      = ss_p;
        wr      = wr_p & ~ss_p;
        sh      = sh_p & ~ss_p & ~wr_p;
        state_d = state_q;
        do_wr   = 1'b0;
        do_sh   = 1'b0;
        unique case (1'b1)
            ss:      state_d = (state_q == RUN) ? STOP : RUN;
            wr:      do_wr = (state_q == RUN) && (count_q < DEPTH_W);
            sh:      do_sh = (count_q != '0);
            default: ;
        endcase
    end

    assign rd_inc = rd_addr_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge key0_rst) begin
        if (!key0_rst) begin
            cnt_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            cnt_en_q  <= (state_d == RUN);
            wr_en_q   <= do_wr;
            wr_addr_q <= (count_q == DEPTH_W) ? DEPTH_W - ADDR_W'(1) : count_q;
            full_q    <= (count_q == DEPTH_W);
            if (do_wr) count_q <= count_q + ADDR_W'(1);
            if (do_sh) begin
                rd_valid_q <= 1'b1;
                if (!rd_valid_q || rd_inc == count_q) rd_addr_q <= '0;
                else                                  rd_addr_q <= rd_inc;
            end
        end
    end

    assign bus.cnt_en   = cnt_en_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.full     = full_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_task_8_timer_ctrl.sv
// Randomised bench for the lap-timer controller against an event-level model.
// Build switch: TASK_8_TIMER_CTRL_DEBOUNCE_EN adds the glitch-rejection test.
module tb_task_8_timer_ctrl;
    import timer_pkg::*;

    localparam int DEB   = 4;
    localparam int DEPTH = 10;
`ifdef TASK_8_TIMER_CTRL_DEBOUNCE_EN
    localparam int LAT = 2 + DEB + 1;
`else
    localparam int LAT = 3;
`endif
    localparam int SETTLE = LAT + 3;

    logic clk = 1'b0;
    logic rst_n;
    logic k1, k2, k3;

    task_8_timer_ctrl_if bus ();

    task_8_timer_ctrl #(.DEBOUNCE_CYC(DEB), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .key0_rst(rst_n),
        .key1_start_stop(k1),
        .key2_write(k2),
        .key3_show(k3),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int m_state, m_count, m_rd;
    bit m_rdv;
    int exp_q[$];

    function automatic void model_reset();
        m_state = 0;
        m_count = 0;
        m_rd    = 0;
        m_rdv   = 1'b0;
        exp_q.delete();
    endfunction

    // One accepted press event, highest priority wins.
    function automatic void model(bit ss, bit wr, bit sh);
        if (ss) begin
            m_state = (m_state == 1) ? 2 : 1;
        end else if (wr) begin
            if (m_state == 1 && m_count < DEPTH) begin
                exp_q.push_back(m_count);
                m_count++;
            end
        end else if (sh) begin
            if (m_count > 0) begin
                if (!m_rdv) begin
                    m_rdv = 1'b1;
                    m_rd  = 0;
                end else begin
                    m_rd = (m_rd + 1) % m_count;
                end
            end
        end
    endfunction

    function automatic logic [12:0] exp_vec();
        int wa;
        wa = (m_count == DEPTH) ? DEPTH - 1 : m_count;
        return {2'(m_state), 1'(m_state == 1), 1'(m_count == DEPTH),
                m_rdv, 4'(m_rd), 4'(wa)};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {bus.state, bus.cnt_en, bus.full, bus.rd_valid,
                bus.rd_addr, bus.wr_addr};
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin
            int e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_pulse got unexpected addr=%0d required none",
                         bus.wr_addr);
            end else begin
                e = exp_q.pop_front();
                if (bus.wr_addr !== 4'(e)) begin
                    failures++;
                    $display("FAIL wr_addr got=%0d required=%0d", bus.wr_addr, e);
                end
            end
        end
    end

    task automatic press(input bit a, input bit b, input bit c, input int hold);
        @(posedge clk); #1;
        k1 = ~a;
        k2 = ~b;
        k3 = ~c;
        repeat (hold) @(posedge clk);
        #1;
        k1 = 1'b1;
        k2 = 1'b1;
        k3 = 1'b1;
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        k1 = 1'b1;
        k2 = 1'b1;
        k3 = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        k1 = 1'b1;
        k2 = 1'b1;
        k3 = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== 13'h0 || bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got=%h required=0", obs_vec());
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle got=%h required=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_latency();
        model(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        k1 = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        checks++;
        if (bus.cnt_en !== 1'b0 || bus.state !== 2'd0) begin
            failures++;
            $display("FAIL latency_early got cnt_en=%b state=%0d required 0/0",
                     bus.cnt_en, bus.state);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.cnt_en !== 1'b1 || bus.state !== 2'd1) begin
            failures++;
            $display("FAIL latency_edge got cnt_en=%b state=%0d required 1/1",
                     bus.cnt_en, bus.state);
        end
        repeat (8 - LAT) @(posedge clk);
        #1 k1 = 1'b1;
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
        model(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 8);
        checks++;
        if (obs_vec() !== exp_vec() || bus.state !== 2'd2) begin
            failures++;
            $display("FAIL stop_press got=%h required=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_write();
        model(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, LAT + 1);
        for (int i = 0; i < 5; i++) begin
            model(1'b0, 1'b1, 1'b0);
            press(1'b0, 1'b1, 1'b0, $urandom_range(LAT + 1, LAT + 6));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL write_%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (exp_q.size() != 0 || bus.wr_addr !== 4'd5 || bus.full !== 1'b0) begin
            failures++;
            $display("FAIL write_final got wr_addr=%0d full=%b missing=%0d required 5/0/0",
                     bus.wr_addr, bus.full, exp_q.size());
        end
    endtask

    task automatic test_show();
        int tbl[7] = '{0, 1, 2, 3, 4, 0, 1};
        for (int i = 0; i < 7; i++) begin
            model(1'b0, 1'b0, 1'b1);
            press(1'b0, 1'b0, 1'b1, $urandom_range(LAT + 1, LAT + 6));
            checks++;
            if (bus.rd_addr !== 4'(tbl[i]) || bus.rd_valid !== 1'b1 ||
                obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL show_%0d got rd_addr=%0d valid=%b required %0d/1",
                         i, bus.rd_addr, bus.rd_valid, tbl[i]);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        model(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1, LAT + 2);
        checks++;
        if (bus.rd_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL show_empty got=%h required=%h", obs_vec(), exp_vec());
        end
        model(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, LAT + 1);
        for (int i = 0; i < 11; i++) begin
            model(1'b0, 1'b1, 1'b0);
            press(1'b0, 1'b1, 1'b0, $urandom_range(LAT + 1, LAT + 4));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL fill_%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.full !== 1'b1 || bus.wr_addr !== 4'd9 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL full_flag got full=%b wr_addr=%0d required 1/9",
                     bus.full, bus.wr_addr);
        end
        model(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, LAT + 1);
        model(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, LAT + 1);
        model(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1, LAT + 1);
        checks++;
        if (obs_vec() !== exp_vec() || bus.state !== 2'd2 || bus.rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL stop_ignore got=%h required=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        model(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, LAT + 1);
        model(1'b1, 1'b1, 1'b0);
        press(1'b1, 1'b1, 1'b0, LAT + 2);
        checks++;
        if (obs_vec() !== exp_vec() || bus.state !== 2'd2) begin
            failures++;
            $display("FAIL ss_over_wr got=%h required=%h", obs_vec(), exp_vec());
        end
        model(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, LAT + 1);
        model(1'b0, 1'b1, 1'b1);
        press(1'b0, 1'b1, 1'b1, LAT + 2);
        checks++;
        if (obs_vec() !== exp_vec() || bus.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_over_show got=%h required=%h", obs_vec(), exp_vec());
        end
    endtask

`ifdef TASK_8_TIMER_CTRL_DEBOUNCE_EN
    task automatic test_glitch();
        @(posedge clk); #1;
        k2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 k2 = 1'b1;
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL glitch got=%h required=%h", obs_vec(), exp_vec());
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        model(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, LAT + 1);
        model(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, LAT + 1);
        @(posedge clk); #1;
        k1 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== 13'h0 || bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got=%h required=0", obs_vec());
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1 k1 = 1'b1;
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec() || bus.state !== 2'd0) begin
            failures++;
            $display("FAIL held_through_reset got=%h required=%h",
                     obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        bit a, b, c;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            a = 1'($urandom_range(0, 3) == 0);
            b = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            model(a, b, c);
            press(a, b, c, $urandom_range(LAT + 1, LAT + 6));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_%0d keys=%b%b%b got=%h required=%h",
                         i, a, b, c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_pulses got missing=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b1;
        k1 = 1'b1;
        k2 = 1'b1;
        k3 = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_latency();
        test_write();
        test_show();
`ifdef TASK_8_TIMER_CTRL_DEBOUNCE_EN
        test_glitch();
`endif
        test_full();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
